// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, 8N1 deframer with optional parity, one-cycle valid pulse.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  // state     | meaning
  // IDLE      | line idle, waiting for rxs low
  // START     | half-bit wait, start bit re-checked (glitch reject)
  // DATA      | 8 data bits, LSB first
  // PARITY    | parity bit sampled and compared
  // STOP      | stop bit sampled, result published
  // WAIT_IDLE | stop bit was low, hold until line returns high
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int FIRST = HALF + 1;  // decide one cycle after centre
`else
  localparam int FIRST = HALF;
`endif
  localparam logic [CW-1:0] FIRST_LD = CW'(FIRST);
  localparam logic [CW-1:0] BIT_LD   = CW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [1:0]    pt_q;
  logic          perr;
  logic          rx_meta;
  logic          rxs;
  logic          bit_val;

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d1, rxs_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
    end
  end

  assign bit_val = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
  assign bit_val = rxs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      pt_q       <= '0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            pt_q    <= parity_type;
            bit_cnt <= '0;
            perr    <= 1'b0;
            cnt     <= FIRST_LD;
            state   <= START;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (bit_val) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt   <= BIT_LD;
            state <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shreg   <= {bit_val, shreg[7:1]};
            cnt     <= BIT_LD;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= (pt_q != 2'b00) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            perr  <= bit_val != (pt_q[0] ? ~^shreg : ^shreg);
            cnt   <= BIT_LD;
            state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            data_out   <= shreg;
            parity_err <= perr;
            frame_err  <= ~bit_val;
            data_valid <= 1'b1;
            if (bit_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the receive-side counterpart of the UART transmit path and its parity generator.
- Samples the asynchronous rx line, deframes 1 start, 8 data (LSB first), optional parity and 1 stop bit.
- Presents the byte with parity and framing status as a one-cycle valid pulse.
- Sits between the pad-level rx input and the byte consumer.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); must be >= 4.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous, idle high.
- parity_type  input  2  2'b00 no parity bit; 2'bx1 odd parity; 2'b10 even parity (same encoding as TX side).
- data_out  output  8  last received byte.
- data_valid  output  1  one-cycle pulse, frame complete.
- parity_err  output  1  status for the frame just completed.
- frame_err  output  1  stop bit sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE, all outputs 0, synchronizer flops set to 1, counters 0.
- rx passes through a 2-flop synchronizer. All decisions use the synchronized value rxs, which has 2 cycles of latency.
- IDLE: when rxs goes 0, capture parity_type into an internal register (held for the whole frame), clear bit counter, go START.
- START: count to (CLKS_PER_BIT-1)/2 (integer), then sample.
  - rxs=1 is a glitch: return to IDLE with no output and no error.
  - rxs=0: go DATA with bit counter 0.
- DATA: sample every CLKS_PER_BIT cycles at bit centre. Shift LSB first into the shift register. After the 8th sample:
  - go PARITY if the latched type != 00;
  - otherwise go STOP.
- PARITY: sample one bit.
  - Expected value: odd gives ~^data; even gives ^data.
  - Mismatch sets an internal perr.
- STOP: sample one bit. On the next clk:
  - data_out <= shift register;
  - parity_err <= perr (0 when no parity);
  - frame_err <= ~stop_sample;
  - data_valid = 1 for exactly that cycle.
  - Then go IDLE if stop_sample=1, else go WAIT_IDLE.
- WAIT_IDLE (break or framing fault): stay until rxs=1, then go IDLE. This prevents a held-low line being re-read as start bits.
- data_out, parity_err and frame_err hold their values until the next data_valid. They are updated even when an error is flagged.
- Latency: data_valid rises 1 clk after the stop-bit centre sample, i.e. about 2 + (CLKS_PER_BIT-1)/2 + (9 or 10)*CLKS_PER_BIT cycles after rx falls.
- Back-to-back frames: a start edge seen in IDLE on the cycle after data_valid is accepted. There is no dead time beyond the half-bit stop sample point.
- parity_type changes mid-frame have no effect on the frame in progress.
- Async reset mid-frame aborts the frame with no data_valid. Reception resumes on the next falling edge after release.
- Bit-period counter width: $clog2(CLKS_PER_BIT). Bit counter: 3 bits. No overflow is possible.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of rxs sampled at centre-1, centre and centre+1. The decision is taken at centre+1, which shifts the output latency by +1 cycle. Start-glitch rejection also uses the majority.
- Undefined: single sample at the centre cycle.

Test Plan (CLKS_PER_BIT=16):
- No parity, send 0xA5 with a good stop bit -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, busy low 1 clk later.
- Odd parity (2'b01), send 0x03 with parity bit 1 -> data_out=0x03, parity_err=0. Repeat with parity bit 0 -> parity_err=1, data_out=0x03.
- Even parity (2'b10), send 0x07 with parity bit 1 -> parity_err=0. Also set parity_type=2'b11 mid-frame -> this frame is still checked as even.
- Stop bit 0 on 0x55, rx held low for 40 bit times then high -> data_valid with frame_err=1, data_out=0x55, no further data_valid while low, state returns to IDLE once rx is high.
- rx low pulse of 4 clk in IDLE -> no data_valid, busy drops back within 10 clk. Then back-to-back frames 0x00 and 0xFF -> two pulses, correct bytes.
- Drive rst_n low during the DATA state of 0x3C -> all outputs 0 immediately, no data_valid. After release, frame 0x81 -> data_out=0x81.
